// File: rtl/instr_mem_responder.sv
// Memory-side responder: DEPTH-word synchronous array behind a req/ready handshake,
// with WAIT_CYCLES wait states. Define MEM_ERR_EN to flag out-of-range accesses on err.
module instr_mem_responder #(
  parameter int DATA_BUS_WIDTH = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int DEPTH          = 256,
  parameter int WAIT_CYCLES    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req,
  input  logic                      we,
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  logic [DATA_BUS_WIDTH-1:0] wdata,
  output logic [DATA_BUS_WIDTH-1:0] mem_data,
  output logic                      ready,
  output logic                      busy,
  output logic                      err
);

  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t                    state_reg;
  logic [3:0]                cnt_reg;
  logic [ADDR_WIDTH-1:0]     addr_reg;
  logic                      we_reg;
  logic [DATA_BUS_WIDTH-1:0] wdata_reg;
  logic [DATA_BUS_WIDTH-1:0] mem_data_reg;
  logic                      ready_reg;
  logic                      busy_reg;

  logic [DATA_BUS_WIDTH-1:0] mem [0:DEPTH-1];

  logic             commit;
  logic             in_range;
  logic [IDX_W-1:0] idx;

  assign commit = (state_reg == ST_WAIT) && (cnt_reg == 4'd0);
  assign idx    = addr_reg[IDX_W-1:0];

  // Only a partially populated address space needs a bound check.
  generate
    if (DEPTH >= (64'(1) << ADDR_WIDTH)) begin : g_full_map
      assign in_range = 1'b1;
    end else begin : g_part_map
      localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
      assign in_range = (addr_reg <= LAST_ADDR);
    end
  endgenerate

  // Array write port kept free of reset so it maps onto block RAM; reset still blocks the commit.
  always_ff @(posedge clk) begin
    if (!reset && commit && we_reg && in_range) begin
      mem[idx] <= wdata_reg;
    end
  end

`ifdef MEM_ERR_EN
  logic err_reg;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 4'd0;
      addr_reg     <= '0;
      we_reg       <= 1'b0;
      wdata_reg    <= '0;
      mem_data_reg <= '0;
      ready_reg    <= 1'b0;
      busy_reg     <= 1'b0;
`ifdef MEM_ERR_EN
      err_reg      <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req) begin
            addr_reg  <= addr;
            we_reg    <= we;
            wdata_reg <= wdata;
            cnt_reg   <= WAIT_INIT;
            busy_reg  <= 1'b1;
            state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            ready_reg <= 1'b1;
            state_reg <= ST_DONE;
`ifdef MEM_ERR_EN
            err_reg <= !in_range;
            if (!in_range) begin
              mem_data_reg <= '0;
            end else if (!we_reg) begin
              mem_data_reg <= mem[idx];
            end
`else
            if (!we_reg) begin
              mem_data_reg <= in_range ? mem[idx] : '0;
            end
`endif
          end
        end
        ST_DONE: begin
          ready_reg <= 1'b0;
          busy_reg  <= 1'b0;
`ifdef MEM_ERR_EN
          err_reg   <= 1'b0;
`endif
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign mem_data = mem_data_reg;
  assign ready    = ready_reg;
  assign busy     = busy_reg;
`ifdef MEM_ERR_EN
  assign err      = err_reg;
`else
  assign err      = 1'b0;
`endif

endmodule
